// File: rtl/iir_biquad_mc_pkg.sv
// Shared types and helpers for the multi-channel biquad cascade.
package iir_pkg;

    localparam int unsigned TAP_W = 3;

    localparam logic [TAP_W-1:0] B0 = 3'd0;
    localparam logic [TAP_W-1:0] B1 = 3'd1;
    localparam logic [TAP_W-1:0] B2 = 3'd2;
    localparam logic [TAP_W-1:0] A1 = 3'd3;
    localparam logic [TAP_W-1:0] A2 = 3'd4;

    // Slot order of the per-channel, per-section history words.
    localparam logic [1:0] H_X1 = 2'd0;
    localparam logic [1:0] H_X2 = 2'd1;
    localparam logic [1:0] H_Y1 = 2'd2;
    localparam logic [1:0] H_Y2 = 2'd3;

    typedef enum logic [1:0] {IDLE, MAC, WB, OUT} state_t;

    // Clamp a signed value to the range of a width-bit two's complement word.
    function automatic logic signed [63:0] sat(input logic signed [63:0] value,
                                              input int unsigned width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (value > hi)
            sat = hi;
        else if (value < lo)
            sat = lo;
        else
            sat = value;
    endfunction

endpackage

// File: rtl/iir_biquad_mc_if.sv
// Sample, result and configuration signals of the biquad cascade.
interface iir_biquad_mc_if #(
    parameter int unsigned DIN_W  = 12,
    parameter int unsigned DOUT_W = 18,
    parameter int unsigned CW     = 16,
    parameter int unsigned NSEC   = 2,
    parameter int unsigned NCH    = 2
);
    localparam int unsigned CH_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned AW   = $clog2(5 * NSEC);

    logic signed [DIN_W-1:0]  din;
    logic [CH_W-1:0]          din_ch;
    logic                     din_valid;
    logic                     din_ready;
    logic signed [DOUT_W-1:0] dout;
    logic [CH_W-1:0]          dout_ch;
    logic                     dout_valid;
    logic                     cfg_we;
    logic [AW-1:0]            cfg_addr;
    logic signed [CW-1:0]     cfg_data;
    logic                     state_clr;
    logic                     busy;

    modport master (
        output din, din_ch, din_valid, cfg_we, cfg_addr, cfg_data, state_clr,
        input  din_ready, dout, dout_ch, dout_valid, busy
    );

    modport slave (
        input  din, din_ch, din_valid, cfg_we, cfg_addr, cfg_data, state_clr,
        output din_ready, dout, dout_ch, dout_valid, busy
    );
endinterface

// File: rtl/iir_biquad_mc_mac.sv
// Shared signed multiply-accumulate with floor-shift and saturating read-out.
module iir_mac
    import iir_pkg::*;
#(
    parameter int unsigned IW = 18,
    parameter int unsigned CW = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 clr,
    input  logic                 sub,
    input  logic signed [CW-1:0] coef,
    input  logic signed [IW-1:0] data,
    output logic signed [IW-1:0] y_c
);
    localparam int unsigned PW    = IW + CW;
    localparam int unsigned ACC_W = IW + CW + 3;

    logic signed [PW-1:0]    prod_c;
    logic signed [ACC_W-1:0] term_c;
    logic signed [ACC_W-1:0] base_c;
    logic signed [ACC_W-1:0] acc_q;

    assign prod_c = PW'(coef) * PW'(data);
    assign term_c = ACC_W'(prod_c);
    assign base_c = clr ? '0 : acc_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            acc_q <= '0;
        else if (en)
            acc_q <= sub ? (base_c - term_c) : (base_c + term_c);
    end

    // Drop the Q2 fraction bits (arithmetic shift floors) and clamp to IW.
    assign y_c = IW'(sat(64'(acc_q >>> (CW - 2)), IW));

endmodule

// File: rtl/iir_biquad_mc.sv
// Multi-channel cascade of direct-form-I biquads sharing one MAC.
module iir_biquad_mc
    import iir_pkg::*;
#(
    parameter int unsigned DIN_W  = 12,
    parameter int unsigned DOUT_W = 18,
    parameter int unsigned CW     = 16,
    parameter int unsigned NSEC   = 2,
    parameter int unsigned NCH    = 2
) (
    input logic            clk,
    input logic            rst,
    iir_biquad_mc_if.slave bus
);
    localparam int unsigned CH_W  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned SEC_W = (NSEC > 1) ? $clog2(NSEC) : 1;
    localparam int unsigned AW    = $clog2(5 * NSEC);
    localparam int unsigned NCOEF = 5 * NSEC;
    localparam logic signed [CW-1:0] COEF_ONE = CW'(2 ** (CW - 2));

    state_t             state_q, state_d;
    logic [SEC_W-1:0]   sec_q, sec_d;
    logic [TAP_W-1:0]   tap_q, tap_d;
    logic               accept_c, mac_en_c, wb_c, out_c, clr_hist_c, cfg_wr_c;

    logic signed [CW-1:0]     coef [NCOEF];
    logic signed [DOUT_W-1:0] hist [NCH][NSEC][4];
    logic signed [DOUT_W-1:0] x_q;
    logic [CH_W-1:0]          ch_q;
    logic                     drop_q;
    logic                     drop_c;
    logic [AW-1:0]            coef_idx_c;
    logic signed [DOUT_W-1:0] opnd_c;
    logic                     neg_c;
    logic signed [DOUT_W-1:0] y_c;

    assign bus.din_ready = (state_q == IDLE) && !bus.state_clr;
    assign bus.busy      = (state_q != IDLE);
    assign drop_c        = 32'(bus.din_ch) >= NCH;
    assign coef_idx_c    = AW'(int'(sec_q) * 5 + int'(tap_q));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            sec_q   <= '0;
            tap_q   <= B0;
        end else begin
            state_q <= state_d;
            sec_q   <= sec_d;
            tap_q   <= tap_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        sec_d      = sec_q;
        tap_d      = tap_q;
        accept_c   = 1'b0;
        mac_en_c   = 1'b0;
        wb_c       = 1'b0;
        out_c      = 1'b0;
        clr_hist_c = 1'b0;
        cfg_wr_c   = 1'b0;
        case (state_q)
            IDLE: begin
                cfg_wr_c = bus.cfg_we && (32'(bus.cfg_addr) < 32'(NCOEF));
                // A clear request takes priority over a waiting sample.
                if (bus.state_clr) begin
                    clr_hist_c = 1'b1;
                end else if (bus.din_valid) begin
                    accept_c = 1'b1;
                    state_d  = MAC;
                    sec_d    = '0;
                    tap_d    = B0;
                end
            end
            MAC: begin
                mac_en_c = 1'b1;
                if (tap_q == A2)
                    state_d = WB;
                else
                    tap_d = tap_q + 3'd1;
            end
            WB: begin
                wb_c  = 1'b1;
                tap_d = B0;
                if (sec_q == SEC_W'(NSEC - 1)) begin
                    state_d = OUT;
                end else begin
                    sec_d   = sec_q + SEC_W'(1);
                    state_d = MAC;
                end
            end
            OUT: begin
                out_c   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand for the current tap; feedback taps are subtracted.
    always_comb begin
        opnd_c = x_q;
        neg_c  = 1'b0;
        case (tap_q)
            B1: opnd_c = hist[ch_q][sec_q][H_X1];
            B2: opnd_c = hist[ch_q][sec_q][H_X2];
            A1: begin
                opnd_c = hist[ch_q][sec_q][H_Y1];
                neg_c  = 1'b1;
            end
            A2: begin
                opnd_c = hist[ch_q][sec_q][H_Y2];
                neg_c  = 1'b1;
            end
            default: opnd_c = x_q;
        endcase
    end

    iir_mac #(.IW(DOUT_W), .CW(CW)) u_mac (
        .clk  (clk),
        .rst  (rst),
        .en   (mac_en_c),
        .clr  (tap_q == B0),
        .sub  (neg_c),
        .coef (coef[coef_idx_c]),
        .data (opnd_c),
        .y_c  (y_c)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_q            <= '0;
            ch_q           <= '0;
            drop_q         <= 1'b0;
            bus.dout       <= '0;
            bus.dout_ch    <= '0;
            bus.dout_valid <= 1'b0;
            for (int c = 0; c < NCH; c++)
                for (int s = 0; s < NSEC; s++)
                    for (int h = 0; h < 4; h++)
                        hist[c][s][h] <= '0;
            for (int i = 0; i < NCOEF; i++)
                coef[i] <= (i % 5 == 0) ? COEF_ONE : '0;
        end else begin
            bus.dout_valid <= out_c && !drop_q;
            if (accept_c) begin
                x_q    <= DOUT_W'(bus.din);
                drop_q <= drop_c;
                ch_q   <= drop_c ? '0 : bus.din_ch;
            end
            if (clr_hist_c) begin
                for (int c = 0; c < NCH; c++)
                    for (int s = 0; s < NSEC; s++)
                        for (int h = 0; h < 4; h++)
                            hist[c][s][h] <= '0;
            end
            // Section output becomes the next section's input.
            if (wb_c) begin
                x_q <= y_c;
                if (!drop_q) begin
                    hist[ch_q][sec_q][H_X2] <= hist[ch_q][sec_q][H_X1];
                    hist[ch_q][sec_q][H_X1] <= x_q;
                    hist[ch_q][sec_q][H_Y2] <= hist[ch_q][sec_q][H_Y1];
                    hist[ch_q][sec_q][H_Y1] <= y_c;
                end
            end
            if (out_c && !drop_q) begin
                bus.dout    <= x_q;
                bus.dout_ch <= ch_q;
            end
            if (cfg_wr_c)
                coef[bus.cfg_addr] <= bus.cfg_data;
        end
    end

endmodule

// File: tb/tb_iir_biquad_mc.sv
// Directed bench for iir_biquad_mc with a reference model feeding a result queue.
module tb_iir_biquad_mc;
    localparam int unsigned DIN_W  = 12;
    localparam int unsigned DOUT_W = 18;
    localparam int unsigned CW     = 16;
    localparam int unsigned NSEC   = 2;
    localparam int unsigned NCH    = 2;
    localparam int unsigned CH_W   = 1;
    localparam int unsigned AW     = 4;
    localparam int          LAT    = 6 * NSEC + 1;

    typedef struct {
        int     ch;
        longint val;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    exp_t   expq[$];
    exp_t   mon_e;
    longint mcoef[5*NSEC];
    longint mhist[NCH][NSEC][4];
    int     n_vec = 0;
    int     n_err = 0;

    always #5 clk = ~clk;

    iir_biquad_mc_if #(.DIN_W(DIN_W), .DOUT_W(DOUT_W), .CW(CW), .NSEC(NSEC), .NCH(NCH)) bus();

    iir_biquad_mc #(.DIN_W(DIN_W), .DOUT_W(DOUT_W), .CW(CW), .NSEC(NSEC), .NCH(NCH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint msat(input longint v);
        longint hi, lo;
        hi = (longint'(1) <<< (DOUT_W - 1)) - 1;
        lo = -(longint'(1) <<< (DOUT_W - 1));
        return (v > hi) ? hi : ((v < lo) ? lo : v);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 5 * NSEC; i++)
            mcoef[i] = (i % 5 == 0) ? (longint'(1) <<< (CW - 2)) : 0;
        for (int c = 0; c < NCH; c++)
            for (int s = 0; s < NSEC; s++)
                for (int h = 0; h < 4; h++)
                    mhist[c][s][h] = 0;
    endtask

    task automatic model_clear();
        for (int c = 0; c < NCH; c++)
            for (int s = 0; s < NSEC; s++)
                for (int h = 0; h < 4; h++)
                    mhist[c][s][h] = 0;
    endtask

    // History order: 0=x[n-1], 1=x[n-2], 2=y[n-1], 3=y[n-2].
    function automatic longint model_run(input int ch, input longint xin);
        longint x, acc, y;
        x = xin;
        for (int s = 0; s < NSEC; s++) begin
            acc = mcoef[s*5] * x + mcoef[s*5+1] * mhist[ch][s][0] + mcoef[s*5+2] * mhist[ch][s][1]
                - mcoef[s*5+3] * mhist[ch][s][2] - mcoef[s*5+4] * mhist[ch][s][3];
            y = msat(acc >>> (CW - 2));
            mhist[ch][s][1] = mhist[ch][s][0];
            mhist[ch][s][0] = x;
            mhist[ch][s][3] = mhist[ch][s][2];
            mhist[ch][s][2] = y;
            x = y;
        end
        return x;
    endfunction

    always @(negedge clk) begin
        if (rst && bus.dout_valid === 1'b1) begin
            if (expq.size() == 0) begin
                chk("spurious_dout_valid", bus.dout_valid, 0);
            end else begin
                mon_e = expq.pop_front();
                chk("dout", bus.dout, mon_e.val);
                chk("dout_ch", bus.dout_ch, mon_e.ch);
            end
        end
    end

    task automatic drive(input int ch, input longint x);
        exp_t e;
        int   n;
        n = 0;
        @(negedge clk);
        while (bus.din_ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) chk("ready_timeout", bus.din_ready, 1);
        bus.din       = DIN_W'(x);
        bus.din_ch    = CH_W'(ch);
        bus.din_valid = 1'b1;
        @(posedge clk);
        #1 bus.din_valid = 1'b0;
        e.ch  = ch;
        e.val = model_run(ch, x);
        expq.push_back(e);
    endtask

    task automatic wait_out(output longint y);
        int n;
        for (n = 1; n <= 60; n++) begin
            @(posedge clk);
            #1;
            if (bus.dout_valid === 1'b1) break;
        end
        if (n > 60) chk("out_timeout", bus.dout_valid, 1);
        y = bus.dout;
    endtask

    task automatic send(input int ch, input longint x, output longint y);
        int n;
        bit rdy_bad;
        rdy_bad = 1'b0;
        drive(ch, x);
        for (n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (bus.dout_valid === 1'b1) break;
            if (bus.din_ready !== 1'b0 || bus.busy !== 1'b1) rdy_bad = 1'b1;
        end
        chk("latency", n, LAT);
        chk("ready_low_while_busy", rdy_bad, 0);
        chk("ready_after_out", bus.din_ready, 1);
        y = bus.dout;
    endtask

    task automatic cfg_write(input int addr, input longint data);
        @(negedge clk);
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = AW'(addr);
        bus.cfg_data = CW'(data);
        @(posedge clk);
        #1 bus.cfg_we = 1'b0;
        if (addr < 5 * NSEC) mcoef[addr] = data;
    endtask

    task automatic clear_hist();
        @(negedge clk);
        bus.state_clr = 1'b1;
        @(posedge clk);
        #1 bus.state_clr = 1'b0;
        model_clear();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors applied", n_vec);
        $fatal(1, "watchdog expired");
    end

    initial begin
        longint y, prev;
        bit     mono_bad, neg_bad, quiet_bad;
        longint t3[6];
        t3 = '{1000, 500, 250, 125, 62, 31};

        bus.din = '0; bus.din_ch = '0; bus.din_valid = 1'b0;
        bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_data = '0; bus.state_clr = 1'b0;
        model_reset();

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", bus.busy, 0);
        chk("rst_dout_valid", bus.dout_valid, 0);
        chk("rst_dout", bus.dout, 0);
        chk("rst_dout_ch", bus.dout_ch, 0);
        @(negedge clk) rst = 1'b1;
        #1 chk("rst_din_ready", bus.din_ready, 1);

        // 1: pass-through defaults
        send(0, 100, y);
        chk("t1_dout", y, 100);

        // 2: half gain with floor rounding
        cfg_write(0, 8192);
        send(0, 1000, y);
        chk("t2_pos", y, 500);
        send(0, -1001, y);
        chk("t2_neg_floor", y, -501);

        // 3: one-pole impulse response
        cfg_write(0, 16384);
        cfg_write(3, -8192);
        clear_hist();
        for (int i = 0; i < 6; i++) begin
            send(0, (i == 0) ? 1000 : 0, y);
            chk("t3_impulse", y, t3[i]);
        end

        // 4: channel isolation
        clear_hist();
        for (int i = 0; i < 4; i++) begin
            send(0, (i == 0) ? 1000 : 0, y);
            chk("t4_ch0", y, t3[i]);
            send(1, 0, y);
            chk("t4_ch1_zero", y, 0);
        end
        send(1, 400, y);
        chk("t4_ch1_impulse", y, 400);
        send(0, 0, y);
        chk("t4_ch0_continues", y, 62);

        // 5: unstable pole saturates without wrapping
        clear_hist();
        cfg_write(3, -32768);
        prev = -1; mono_bad = 1'b0; neg_bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            send(0, 2047, y);
            if (y < prev) mono_bad = 1'b1;
            if (y < 0) neg_bad = 1'b1;
            prev = y;
        end
        chk("t5_monotonic", mono_bad, 0);
        chk("t5_no_wrap", neg_bad, 0);
        chk("t5_clamp", y, 131071);

        // 6a: configuration writes dropped while busy
        clear_hist();
        cfg_write(3, 0);
        drive(0, 10);
        repeat (3) @(negedge clk);
        chk("t6_busy_at_cfg", bus.busy, 1);
        bus.cfg_we = 1'b1; bus.cfg_addr = AW'(0); bus.cfg_data = CW'(8192);
        @(negedge clk) bus.cfg_we = 1'b0;
        wait_out(y);
        chk("t6_busy_sample", y, 10);
        send(0, 100, y);
        chk("t6_coef_kept", y, 100);

        // 6b: clear beats a simultaneous sample
        cfg_write(3, -8192);
        send(0, 1000, y);
        @(negedge clk);
        bus.state_clr = 1'b1; bus.din = DIN_W'(500); bus.din_ch = '0; bus.din_valid = 1'b1;
        #1 chk("t6_clr_ready_low", bus.din_ready, 0);
        @(posedge clk);
        #1;
        bus.state_clr = 1'b0; bus.din_valid = 1'b0;
        model_clear();
        chk("t6_clr_not_accepted", bus.busy, 0);
        send(0, 1000, y);
        chk("t6_fresh_impulse", y, 1000);

        // 6c: reset during MAC aborts the sample and restores coefficients
        cfg_write(0, 8192);
        drive(0, 100);
        repeat (3) @(posedge clk);
        #1 chk("t6_busy_before_rst", bus.busy, 1);
        @(negedge clk) rst = 1'b0;
        @(negedge clk) rst = 1'b1;
        expq.delete();
        model_reset();
        chk("t6_rst_busy", bus.busy, 0);
        chk("t6_rst_dout", bus.dout, 0);
        quiet_bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (bus.dout_valid !== 1'b0) quiet_bad = 1'b1;
        end
        chk("t6_no_valid_after_rst", quiet_bad, 0);
        send(0, 100, y);
        chk("t6_defaults_restored", y, 100);

        repeat (3) @(posedge clk);
        chk("queue_drained", expq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/iir_biquad_mc.md
Name: iir_biquad_mc

Overview:
Parametrised successor of the team's single-channel multi-cycle IIR filter. It is a cascade of NSEC direct-form-I biquad sections, time-multiplexed over NCH independent channels, and uses one shared multiply-accumulator. Coefficients are runtime-loadable through a config port; sample flow uses a valid/ready handshake. It sits between the ADC sample stream and the downstream decimation/logging path.

Parameters:
DIN_W, 12, signed input sample width
DOUT_W, 18, signed output and inter-section width (IW)
CW, 16, signed coefficient width, format Q2.(CW-2); 1.0 = 2^(CW-2)
NSEC, 2, number of cascaded biquad sections (1..8)
NCH, 2, number of channels (1..8)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
din  in  DIN_W  signed input sample
din_ch  in  clog2(NCH)  channel of din
din_valid  in  1  din/din_ch valid
din_ready  out  1  block can accept a sample this cycle
dout  out  DOUT_W  signed filtered sample
dout_ch  out  clog2(NCH)  channel of dout
dout_valid  out  1  one-cycle strobe, dout valid
cfg_we  in  1  coefficient write strobe
cfg_addr  in  clog2(5*NSEC)  coefficient index = 5*section + {B0,B1,B2,A1,A2}
cfg_data  in  CW  coefficient value
state_clr  in  1  clear all channel history
busy  out  1  processing a sample (not IDLE)

Behaviour:
- Reset (rst=0, async): FSM in IDLE; dout=0, dout_ch=0, dout_valid=0, busy=0, din_ready=1 after release. All history is 0. Coefficients reset to pass-through: B0=2^(CW-2) and all others 0 for every section.
- Section equation: y = sat_IW((B0*x + B1*x1 + B2*x2 - A1*y1 - A2*y2) >>> (CW-2)). The shift is arithmetic (floor). The accumulator is IW+CW+3 bits, so it never overflows. sat clamps to [-2^(IW-1), 2^(IW-1)-1].
- din is sign-extended to IW before section 0. The input of section n is the saturated output of section n-1. dout is the output of the last section.
- History x1, x2, y1, y2 is stored per channel per section (NCH*NSEC*4 words of IW).
- FSM states:
  - IDLE: din_ready=1. On din_valid, latch din and din_ch, then go to MAC with sec=0, tap=0.
  - MAC: 5 cycles, taps B0, B1, B2, A1, A2, one product per cycle. Then go to WB.
  - WB: 1 cycle. Shift history (x2<=x1, x1<=x, y2<=y1, y1<=y). y becomes the next section's x. If sec<NSEC-1, go to MAC with sec+1; otherwise go to OUT.
  - OUT: dout, dout_ch and dout_valid=1 for exactly one cycle, then IDLE.
- Latency: dout_valid rises 6*NSEC+1 cycles after the accepting edge. Throughput is one sample per 6*NSEC+2 cycles.
- din_ready=0 and busy=1 in MAC, WB and OUT. din_valid outside IDLE is ignored and not queued.
- cfg_we is applied only in IDLE. Writes while busy=1 are dropped. cfg_addr >= 5*NSEC is ignored.
- state_clr is honoured only in IDLE. It zeroes all history in one cycle. If state_clr and din_valid are both asserted in IDLE, the clear wins and the sample is not accepted (din_ready=0 that cycle).
- din_ch >= NCH: the sample is accepted and discarded. No dout_valid is produced and no history changes.
- An async reset mid-operation aborts the sample: no dout_valid is emitted and the coefficients revert to defaults.

Decomposition:
- Package iir_pkg holds:
  - the tap index constants B0=0, B1=1, B2=2, A1=3, A2=4;
  - the FSM state enum {IDLE, MAC, WB, OUT};
  - a saturate function, sat(value, width).
- Sub-module iir_mac contains the signed multiplier plus accumulator. Its controls are clr, add/sub, and a shift-and-saturate output stage.
- The top level holds the FSM, coefficient file and history RAM.

Test Plan:
1. Defaults (NSEC=2, NCH=2), din=100 ch0 -> dout=100, dout_ch=0, dout_valid exactly 13 cycles after acceptance; din_ready low for 13 cycles.
2. Sec0 B0=8192 (0.5), din=1000 -> dout=500; din=-1001 -> dout=-501 (floor).
3. Sec0 B0=16384, A1=-8192; impulse 1000 then zeros on ch0 -> dout 1000, 500, 250, 125, 62, 31.
4. Same coefficients, impulse on ch0 interleaved with zeros on ch1 -> ch1 dout stays 0 and the ch0 sequence is unchanged (channel isolation).
5. Sec0 B0=16384, A1=-32768; din=2047 held -> dout grows monotonically, clamps at 131071, and never wraps negative.
6. cfg_we asserted while busy -> coefficient unchanged. state_clr with din_valid in IDLE -> sample not accepted and next impulse response starts fresh. rst pulsed mid-MAC -> no dout_valid, and a subsequent din=100 yields 100.
